// File: rtl/adc_snp_cal_capture_ctrl.sv
// ----------------------------------------------------------------------------
// adc_snp_cal_capture_ctrl
//   Capture controller for the ADC-input calibration snapshot path
//   (user_clk domain). Software arms and triggers the capture through a
//   control word. A fixed block of 2**ADDR_W I/Q samples is then written
//   into the snapshot BRAM. Clipped samples are counted along the way.
//
// Ports
//   user_clk        sole clock, rising edge
//   user_rst_n      asynchronous active-low reset
//   ctrl_in[31:0]   bit0 arm (rising edge), bit1 soft trigger (rising edge),
//                   bit2 clear (level); other bits ignored
//   ext_trig        external trigger, level
//   adc_valid       qualifies adc_i / adc_q
//   adc_i, adc_q    signed I/Q samples, SAMP_W bits each
//   bram_we         snapshot BRAM write enable
//   bram_addr       snapshot BRAM write address
//   bram_data       {sext(adc_i), sext(adc_q)}, 16 bits each
//   user_data_out   status word: [31:30] state, [29] clip flag,
//                   [28:21] clip count, [20:16] 0, [15:0] sample count
// ----------------------------------------------------------------------------
module adc_snp_cal_capture_ctrl #(
    parameter int SAMP_W     = 12,
    parameter int ADDR_W     = 11,
    parameter int CLIP_CNT_W = 8
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_in,
    input  logic              ext_trig,
    input  logic              adc_valid,
    input  logic [SAMP_W-1:0] adc_i,
    input  logic [SAMP_W-1:0] adc_q,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_data,
    output logic [31:0]       user_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam logic [SAMP_W-1:0]     SAMP_MAXP = {1'b0, {(SAMP_W-1){1'b1}}};
    localparam logic [SAMP_W-1:0]     SAMP_MAXN = {1'b1, {(SAMP_W-1){1'b0}}};
    localparam logic [ADDR_W:0]       CNT_LAST  = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]       CNT_ONE   = 1;
    localparam logic [CLIP_CNT_W-1:0] CLIP_ONE  = 1;

    state_t                r_state;
    logic [ADDR_W:0]       r_count;      // one bit wider so the final value 2**ADDR_W is visible
    logic [CLIP_CNT_W-1:0] r_clip_cnt;
    logic                  r_clip_flag;
    logic [1:0]            r_ctrl_prev;

    logic        w_arm_edge;
    logic        w_trig;
    logic        w_clear;
    logic        w_clip;
    logic [15:0] w_i16;
    logic [15:0] w_q16;
    logic [31:0] w_status;
    logic        w_unused_ctrl;

    assign w_arm_edge    = ctrl_in[0] & ~r_ctrl_prev[0];
    assign w_trig        = (ctrl_in[1] & ~r_ctrl_prev[1]) | ext_trig;
    assign w_clear       = ctrl_in[2];
    assign w_unused_ctrl = ^ctrl_in[31:3];

    // I and Q clipping together in one sample still counts once
    assign w_clip = (adc_i == SAMP_MAXP) || (adc_i == SAMP_MAXN) ||
                    (adc_q == SAMP_MAXP) || (adc_q == SAMP_MAXN);

    assign w_i16 = 16'($signed(adc_i));
    assign w_q16 = 16'($signed(adc_q));

    // Built from the current register values. It is registered below, so
    // software always sees the state as it was one cycle earlier.
    assign w_status = {r_state, r_clip_flag, 8'(r_clip_cnt), 5'd0, 16'(r_count)};

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_clip_cnt    <= '0;
            r_clip_flag   <= 1'b0;
            r_ctrl_prev   <= 2'b00;
            bram_we       <= 1'b0;
            bram_addr     <= '0;
            bram_data     <= '0;
            user_data_out <= '0;
        end else begin
            r_ctrl_prev   <= ctrl_in[1:0];
            user_data_out <= w_status;
            bram_we       <= 1'b0;
            if (w_clear) begin
                // Clear overrides everything, so arm and trigger are ignored in this cycle
                r_state     <= IDLE;
                r_count     <= '0;
                r_clip_cnt  <= '0;
                r_clip_flag <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (w_arm_edge) begin
                            r_state     <= ARMED;
                            r_count     <= '0;
                            r_clip_cnt  <= '0;
                            r_clip_flag <= 1'b0;
                        end
                    end
                    ARMED: begin
                        // The sample on the trigger cycle itself is not captured
                        if (w_trig) r_state <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (adc_valid) begin
                            bram_we   <= 1'b1;
                            bram_addr <= r_count[ADDR_W-1:0];
                            bram_data <= {w_i16, w_q16};
                            r_count   <= r_count + CNT_ONE;
                            if (w_clip) begin
                                r_clip_flag <= 1'b1;
                                if (r_clip_cnt != '1) r_clip_cnt <= r_clip_cnt + CLIP_ONE;
                            end
                            if (r_count == CNT_LAST) r_state <= DONE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/adc_snp_cal_capture_ctrl.md
Name: adc_snp_cal_capture_ctrl

Overview:
- Capture controller for the ADC-input calibration snapshot path, in the user_clk domain.
- Arms and triggers from a software control word, then writes a fixed-length block of I/Q samples into the snapshot BRAM.
- Counts clipped samples during capture.
- Drives the 32-bit status word consumed directly downstream by the cal1 snapshot status software register (user_data_in).

Parameters:
- SAMP_W, 12, ADC sample width per rail (signed two's complement), 2..16.
- ADDR_W, 11, snapshot BRAM address width; capture length = 2**ADDR_W samples; 1..15.
- CLIP_CNT_W, 8, clip counter width; saturating.

Ports:
- user_clk  in  1  sole clock; all logic rising-edge.
- user_rst_n  in  1  asynchronous active-low reset.
- ctrl_in  in  32  software control word. Bit0 arm (rising edge). Bit1 soft trigger (rising edge). Bit2 clear (level). Other bits ignored.
- ext_trig  in  1  external trigger, level, sampled each cycle.
- adc_valid  in  1  qualifies adc_i/adc_q this cycle.
- adc_i  in  SAMP_W  I sample.
- adc_q  in  SAMP_W  Q sample.
- bram_we  out  1  snapshot BRAM write enable.
- bram_addr  out  ADDR_W  snapshot BRAM write address.
- bram_data  out  32  [31:16] = adc_i sign-extended, [15:0] = adc_q sign-extended.
- user_data_out  out  32  status word to the status register.

Behaviour:
- Reset (user_rst_n low, async):
  - state IDLE; sample count, clip count, clip flag and ctrl edge registers all 0.
  - bram_we=0, bram_addr=0, bram_data=0, user_data_out=0.
- Edge detect: ctrl_in bit0 and bit1 are registered each cycle. A rising edge is current=1 and previous=0. Reset value of previous is 0, so a bit held high through reset fires once after reset.
- States and codes: IDLE=00, ARMED=01, CAPTURE=10, DONE=11.
- Clear (bit2=1):
  - highest priority, evaluated every cycle.
  - next state IDLE; count, clip count and clip flag zeroed; bram_we forced 0 next cycle.
  - arm and trigger are ignored while clear is high.
- IDLE or DONE + arm edge -> ARMED; count, clip count and clip flag zeroed.
- ARMED + (trigger edge OR ext_trig=1) -> CAPTURE. The trigger-cycle sample is NOT captured; the first capturable sample is on the following cycle.
- Arm edge in ARMED or CAPTURE: ignored. Trigger in IDLE or DONE: ignored.
- CAPTURE, adc_valid=1:
  - registers bram_we=1, bram_addr=count[ADDR_W-1:0], bram_data from current samples (write latency 1 cycle).
  - count increments (ADDR_W+1 bits).
  - cycles with adc_valid=0: bram_we=0, count holds; gaps are allowed.
- Capture end: the write with count = 2**ADDR_W-1 is the last. The state goes to DONE in the same update, with count = 2**ADDR_W. No further writes until re-armed.
- Clip detection: in CAPTURE with adc_valid=1, a sample clips if adc_i or adc_q equals max positive (2**(SAMP_W-1)-1) or most negative (-2**(SAMP_W-1)).
  - each clipping sample: clip count +1, saturating at all-ones; clip flag set sticky.
  - I and Q both clipping in one sample counts once.
- Status word (user_data_out), registered, reflecting register values of the previous cycle (one-cycle lag):
  - [31:30] state code
  - [29] clip flag
  - [28:21] clip count, zero-extended or truncated to 8 bits
  - [20:16] 0
  - [15:0] count, zero-extended
- Reset mid-capture: immediate IDLE; any partial BRAM contents are left undefined to software.

Test Plan:
- Reset then idle 10 cycles -> user_data_out=0x00000000, bram_we never asserted.
- Arm edge, soft trigger edge, 2048 consecutive valid non-clipping samples (adc_i=n, adc_q=-n) -> exactly 2048 writes at addr 0..2047, then no writes; bram_data at addr 5 = 0x0005FFFB; final status = 0xC0000800.
- Capture with adc_valid toggling every other cycle -> still 2048 writes, addresses contiguous; status at mid-point shows state 10 and count = number of valid samples so far.
- 3 samples with adc_i=0x7FF, 1 with adc_q=0x800, 1 with both clipping -> clip count=5, bit29=1; second run with 300 clipping samples -> clip count=255.
- Clear asserted after 100 writes -> next cycle bram_we=0, status=0x00000000 within two cycles; a trigger edge while clear is high causes no transition.
- Arm edge during CAPTURE -> ignored, capture completes normally; arm from DONE -> status 0x40000000, count and clip fields cleared; ext_trig held high -> CAPTURE the next cycle.
